// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encodings and defaults.
// Imported by the sequencer top and its next-PC selector.
package pc_sequencer_pkg;

  localparam int          DEF_ADDR_WIDTH   = 16;
  localparam int          DEF_CNT_WIDTH    = 16;
  localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;
  localparam logic [15:0] DEF_PC_INC       = 16'h0001;

  localparam logic [2:0] BOOT   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] ISSUE  = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] UPDATE = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

endpackage

// File: rtl/next_pc_select.sv
// Next-PC priority mux: jump over branch over sequential increment.
// Halt is resolved by the FSM, which simply skips the PC capture.
module next_pc_select
  import pc_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(DEF_PC_INC)
) (
  input  logic [ADDR_WIDTH-1:0] pc_cur,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] npc
);

  always_comb begin
    npc = pc_cur + PC_INC;
    if (jump) begin
      npc = jump_target;
    end else if (branch_taken) begin
      npc = branch_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/commit controller driving an external, reset-less
// program_counter through pc_next/pc_write.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEF_RESET_VECTOR),
  parameter logic [ADDR_WIDTH-1:0] PC_INC       = ADDR_WIDTH'(DEF_PC_INC),
  parameter int                    CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_cur,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  pc_write,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  output logic                  instr_valid,
  input  logic                  exec_done,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  halt,
  input  logic                  stall,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  retired_cnt,
  output logic [2:0]            state_dbg
);

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] npc;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  done;

  next_pc_select #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PC_INC     (PC_INC)
  ) u_npc (
    .pc_cur        (pc_cur),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .npc           (npc)
  );

  assign done = (state == EXEC) && exec_done && !stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = BOOT;
    unique case (state)
      BOOT:    state_nx = FETCH;
      FETCH:   state_nx = (imem_ready && !stall) ? ISSUE : FETCH;
      ISSUE:   state_nx = EXEC;
      EXEC:    state_nx = !done ? EXEC : (halt ? HALT : UPDATE);
      UPDATE:  state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = BOOT;
    endcase
  end

  // Halting retires the instruction but leaves the PC where it is.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
    end else if (done) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
      if (!halt) begin
        pc_q <= npc;
      end
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    pc_next     = pc_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state)
      BOOT: begin
        pc_write = 1'b1;
        pc_next  = RESET_VECTOR;
      end
      FETCH:   imem_req    = 1'b1;
      ISSUE:   instr_valid = 1'b1;
      UPDATE:  pc_write    = 1'b1;
      HALT:    halted      = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr   = pc_cur;
  assign retired_cnt = cnt_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: instruction-level PC model predicts each fetch.
// A second instance boots at 0xFFFF to exercise the wrap.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] pc_cur;
  logic [15:0] pc_next;
  logic        pc_write;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        instr_valid;
  logic        exec_done;
  logic        jump;
  logic [15:0] jump_target;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt;
  logic        stall;
  logic        halted;
  logic [15:0] retired_cnt;
  logic [2:0]  state_dbg;

  logic        reset2;
  logic [15:0] pc_cur2;
  logic [15:0] pc_next2;
  logic        pc_write2;
  logic        imem_req2;
  logic [15:0] imem_addr2;
  logic        imem_ready2;
  logic        instr_valid2;
  logic        exec_done2;
  logic        halted2;
  logic [15:0] retired_cnt2;
  logic [2:0]  state_dbg2;
  logic        zero1;
  logic [15:0] zero16;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  exp_t        e;
  int          acc_times[$];
  logic        acc_prev = 1'b0;
  logic [15:0] pc_model;
  logic [15:0] cnt_model;
  logic        done2 = 1'b0;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .pc_cur        (pc_cur),
    .pc_next       (pc_next),
    .pc_write      (pc_write),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .stall         (stall),
    .halted        (halted),
    .retired_cnt   (retired_cnt),
    .state_dbg     (state_dbg)
  );

  pc_sequencer #(.RESET_VECTOR(16'hFFFF)) dut_w (
    .clk           (clk),
    .reset         (reset2),
    .pc_cur        (pc_cur2),
    .pc_next       (pc_next2),
    .pc_write      (pc_write2),
    .imem_req      (imem_req2),
    .imem_addr     (imem_addr2),
    .imem_ready    (imem_ready2),
    .instr_valid   (instr_valid2),
    .exec_done     (exec_done2),
    .jump          (zero1),
    .jump_target   (zero16),
    .branch_taken  (zero1),
    .branch_target (zero16),
    .halt          (zero1),
    .stall         (zero1),
    .halted        (halted2),
    .retired_cnt   (retired_cnt2),
    .state_dbg     (state_dbg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External program_counter: plain register, no reset.
  always @(posedge clk) begin
    if (pc_write) pc_cur <= pc_next;
    if (pc_write2) pc_cur2 <= pc_next2;
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    imem_ready    = 1'($urandom % 2);
    stall         = 1'($urandom % 2);
    exec_done     = 1'($urandom % 2);
    jump          = 1'($urandom % 2);
    branch_taken  = 1'($urandom % 2);
    halt          = 1'($urandom % 2);
    jump_target   = 16'($urandom);
    branch_target = 16'($urandom);
  endtask

  // Monitor: every accepted fetch is checked against the scoreboard.
  always @(negedge clk) begin
    if (reset && imem_req && imem_ready && !stall) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fetch", {16'h0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("fetch_addr", {16'h0, imem_addr}, {16'h0, e.addr});
        chk("fetch_cnt", {16'h0, retired_cnt}, {16'h0, e.cnt});
      end
      acc_times.push_back(cyc);
    end
    if (instr_valid || acc_prev)
      chk("issue_after_fetch", {31'h0, instr_valid}, {31'h0, acc_prev});
    acc_prev = reset && imem_req && imem_ready && !stall;
    if (halted) chk("halt_no_write", {31'h0, pc_write}, 32'h0);
  end

  task automatic run_instr(input logic j, input logic [15:0] jt,
                           input logic b, input logic [15:0] bt,
                           input logic h, input int rdly, input int sdly,
                           input int edly, input logic rst_exec);
    int t;
    logic [15:0] nx;
    t = 0;
    while (!imem_req && t < 100) begin
      noise();
      step();
      t++;
    end
    if (!imem_req) begin
      chk("fetch_timeout", 32'h0, 32'h1);
      return;
    end
    repeat (rdly) begin
      noise();
      imem_ready = 1'b0;
      step();
    end
    repeat (sdly) begin
      noise();
      imem_ready = 1'b1;
      stall = 1'b1;
      step();
      chk("stall_req", {31'h0, imem_req}, 32'h1);
      chk("stall_state", {29'h0, state_dbg}, {29'h0, FETCH});
    end
    noise();
    imem_ready = 1'b1;
    stall = 1'b0;
    step();
    noise();
    step();
    repeat (edly) begin
      noise();
      if ($urandom % 2 == 1) begin
        exec_done = 1'b1;
        stall = 1'b1;
      end else begin
        exec_done = 1'b0;
      end
      step();
    end
    noise();
    exec_done = 1'b1;
    stall = 1'b0;
    jump = j;
    jump_target = jt;
    branch_taken = b;
    branch_target = bt;
    halt = h;
    if (rst_exec) begin
      reset = 1'b0;
    end else begin
      cnt_model = cnt_model + 16'd1;
      if (!h) begin
        nx = j ? jt : (b ? bt : pc_model + 16'd1);
        pc_model = nx;
        exp_q.push_back('{nx, cnt_model});
      end
    end
    step();
    noise();
  endtask

  // Second instance: always-ready memory and execute, sequential flow.
  initial begin
    logic [15:0] wexp [3];
    int t;
    wexp[0] = 16'hFFFF;
    wexp[1] = 16'h0000;
    wexp[2] = 16'h0001;
    zero1 = 1'b0;
    zero16 = 16'h0;
    reset2 = 1'b0;
    imem_ready2 = 1'b1;
    exec_done2 = 1'b1;
    step();
    step();
    chk("w_boot_pcnext", {16'h0, pc_next2}, 32'hFFFF);
    chk("w_boot_write", {31'h0, pc_write2}, 32'h1);
    reset2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (!imem_req2 && t < 50) begin
        step();
        t++;
      end
      if (!imem_req2) begin
        chk("w_fetch_timeout", 32'h0, 32'h1);
      end else begin
        chk("w_fetch_addr", {16'h0, imem_addr2}, {16'h0, wexp[k]});
        chk("w_fetch_cnt", {16'h0, retired_cnt2}, k);
      end
      step();
    end
    done2 = 1'b1;
  end

  initial begin
    int t;
    reset = 1'b0;
    noise();
    step();
    step();
    step();
    chk("rst_state", {29'h0, state_dbg}, {29'h0, BOOT});
    chk("rst_pc_write", {31'h0, pc_write}, 32'h1);
    chk("rst_pc_next", {16'h0, pc_next}, 32'h0);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_retired", {16'h0, retired_cnt}, 32'h0);
    chk("rst_pc_cur", {16'h0, pc_cur}, 32'h0);
    pc_model = 16'h0;
    cnt_model = 16'h0;
    exp_q.push_back('{16'h0, 16'h0});
    reset = 1'b1;

    repeat (3) run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("retired_three", {16'h0, retired_cnt}, 32'd3);
    run_instr(1, 16'h0040, 1, 16'h0080, 0, 0, 0, 0, 0);
    if (acc_times.size() < 4) begin
      chk("pitch_count", acc_times.size(), 32'd4);
    end else begin
      for (int i = 1; i < 4; i++)
        chk("fetch_pitch", acc_times[i] - acc_times[i-1], 32'd4);
    end

    run_instr(0, 0, 0, 0, 0, 0, 5, 0, 0);

    for (int i = 0; i < 40; i++)
      run_instr(1'($urandom % 4 == 0), 16'($urandom),
                1'($urandom % 3 == 0), 16'($urandom), 0,
                $urandom % 3, $urandom % 3, $urandom % 3, 0);

    run_instr(1, 16'h1234, 0, 0, 0, 1, 1, 2, 1);
    chk("rexec_state", {29'h0, state_dbg}, {29'h0, BOOT});
    chk("rexec_retired", {16'h0, retired_cnt}, 32'h0);
    chk("rexec_pc_write", {31'h0, pc_write}, 32'h1);
    chk("rexec_pc_next", {16'h0, pc_next}, 32'h0);
    exp_q.delete();
    pc_model = 16'h0;
    cnt_model = 16'h0;
    exp_q.push_back('{16'h0, 16'h0});
    step();
    chk("rexec_pc_cur", {16'h0, pc_cur}, 32'h0);
    reset = 1'b1;

    run_instr(1, 16'h0005, 0, 0, 0, 0, 0, 1, 0);
    run_instr(0, 0, 0, 0, 1, 1, 0, 1, 0);
    chk("halt_state", {29'h0, state_dbg}, {29'h0, HALT});
    chk("halt_flag", {31'h0, halted}, 32'h1);
    chk("halt_retired", {16'h0, retired_cnt}, 32'd2);
    chk("halt_pc", {16'h0, pc_cur}, 32'h5);
    repeat (6) begin
      noise();
      exec_done = 1'b1;
      stall = 1'b0;
      step();
      chk("halt_hold", {31'h0, halted}, 32'h1);
      chk("halt_hold_cnt", {16'h0, retired_cnt}, 32'd2);
      chk("halt_hold_pc", {16'h0, pc_cur}, 32'h5);
      chk("halt_no_req", {31'h0, imem_req}, 32'h0);
    end
    chk("sb_drain", exp_q.size(), 32'h0);

    t = 0;
    while (!done2 && t < 200) begin
      step();
      t++;
    end
    if (!done2) chk("wrap_timeout", 32'h0, 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle fetch/commit controller that sequences the program_counter register.
- Drives the program counter's PCin and PCWrite, and reads back its PCout.
- Issues instruction-memory requests and hands each fetched instruction to the execute stage.
- Selects the next PC: sequential, branch or jump.
- Owns boot and halt, because program_counter has no reset of its own.

Parameters:
- ADDR_WIDTH, 16, width of the PC and of all addresses.
- RESET_VECTOR, 0, PC value loaded at boot.
- PC_INC, 1, sequential increment (word-addressed).
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- pc_cur  in  ADDR_WIDTH  current PC, connected to program_counter PCout.
- pc_next  out  ADDR_WIDTH  connected to program_counter PCin.
- pc_write  out  1  connected to program_counter PCWrite.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  ADDR_WIDTH  fetch address.
- imem_ready  in  1  memory data valid; memory holds it stable while imem_req=1.
- instr_valid  out  1  one-cycle pulse: the instruction is handed to execute.
- exec_done  in  1  execute finished the current instruction.
- jump  in  1  valid with exec_done; redirect to jump_target.
- jump_target  in  ADDR_WIDTH  jump destination.
- branch_taken  in  1  valid with exec_done; redirect to branch_target.
- branch_target  in  ADDR_WIDTH  branch destination.
- halt  in  1  valid with exec_done; stop after this instruction.
- stall  in  1  freeze request from the hazard or debug logic.
- halted  out  1  sequencer is in HALT.
- retired_cnt  out  CNT_WIDTH  count of completed instructions.
- state_dbg  out  3  current state encoding.

Behaviour:
- FSM states:
  - BOOT=0
  - FETCH=1
  - ISSUE=2
  - EXEC=3
  - UPDATE=4
  - HALT=5
  - Encodings 6–7 are unreachable; if entered, go to BOOT.
- Reset (reset=0 at posedge):
  - State goes to BOOT.
  - retired_cnt=0, imem_req=0, instr_valid=0, halted=0.
  - pc_next register = RESET_VECTOR.
  - Reset is honoured in every state, including mid-fetch; an outstanding fetch is abandoned.
- Output decoding: all outputs are Moore, decoded from the state plus the pc_next register.
- BOOT:
  - pc_write=1 and pc_next=RESET_VECTOR, also while reset is held, so program_counter preloads.
  - Next state is FETCH; stall is ignored.
- FETCH:
  - imem_req=1, imem_addr=pc_cur.
  - If imem_ready=1 and stall=0, go to ISSUE; otherwise stay.
  - stall=1 overrides imem_ready; imem_req stays high.
- ISSUE:
  - instr_valid=1 for exactly one cycle; imem_req=0.
  - Next state is EXEC unconditionally.
- EXEC waits for exec_done=1 with stall=0. On that cycle:
  - retired_cnt increments, wrapping modulo 2^CNT_WIDTH.
  - If halt=1, go to HALT; the PC is not written.
  - Otherwise capture the next PC into the pc_next register and go to UPDATE.
- Next-PC priority: halt > jump > branch_taken > sequential (pc_cur + PC_INC).
  - The sum is truncated to ADDR_WIDTH, so it wraps from 0xFFFF to 0x0000.
- UPDATE:
  - pc_write=1 for one cycle; program_counter loads pc_next at this edge.
  - Next state is FETCH; stall is ignored, because commit is atomic.
- HALT:
  - halted=1, pc_write=0, imem_req=0.
  - Stays in HALT until reset; all inputs are ignored.
- pc_write is 0 in every state except BOOT and UPDATE.
- Latency:
  - Minimum is 4 cycles per instruction (FETCH, ISSUE, EXEC, UPDATE) with imem_ready and exec_done returned immediately.
  - After UPDATE, pc_cur shows the new PC in the following FETCH cycle.
- Inputs outside the EXEC exec_done cycle (jump, branch, halt) are ignored.

Decomposition:
- Shared package holds:
  - state encodings (localparams BOOT..HALT, 3 bits);
  - default ADDR_WIDTH=16 and RESET_VECTOR;
  - PC_INC.
- One sub-module, next_pc_select: combinational priority mux plus incrementer (inputs pc_cur, jump/jump_target, branch_taken/branch_target; output the next-PC value).
- The FSM, counter and output decode stay in pc_sequencer.

Test Plan:
1. Reset low 3 cycles, then high; memory and execute respond immediately →
   - pc_write=1 in BOOT and PC=0x0000;
   - imem_addr sequence 0x0000, 0x0001, 0x0002 at a 4-cycle pitch;
   - retired_cnt=3 after three instructions.
2. Second instruction returns jump=1, jump_target=0x0040 together with branch_taken=1, branch_target=0x0080 → next FETCH imem_addr=0x0040 (jump wins).
3. Boot with RESET_VECTOR=0xFFFF; one sequential instruction → next fetch address is 0x0000 (wrap).
4. stall=1 held 5 cycles during FETCH with imem_ready=1 →
   - state stays FETCH and imem_req stays 1;
   - no instr_valid;
   - on stall release, ISSUE follows next cycle.
5. exec_done=1 with halt=1 at PC 0x0005 →
   - state HALT, halted=1, no further pc_write and PC stays 0x0005;
   - retired_cnt increments once;
   - exec_done pulses afterwards are ignored.
6. Assert reset=0 during EXEC with exec_done=1 on the same edge →
   - BOOT next cycle, retired_cnt=0, no UPDATE;
   - PC reloads to RESET_VECTOR.
